// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared ucrv32 constants and types used by the pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            we;
    logic            err;
  } wb_result_t;

endpackage
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_if
// Purpose  : ALU/load result handshakes and register-file write/bypass port.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_stage_if;

  logic                          alu_valid_i;
  logic                          alu_ready_o;
  logic [riscv_pkg::RA_W-1:0]    alu_rd_i;
  logic [riscv_pkg::XLEN-1:0]    alu_result_i;

  logic                          ld_valid_i;
  logic                          ld_ready_o;
  logic [riscv_pkg::RA_W-1:0]    ld_rd_i;
  logic [riscv_pkg::XLEN-1:0]    ld_rdata_i;
  logic [1:0]                    ld_addr_lo_i;
  logic [2:0]                    ld_funct3_i;

  logic [riscv_pkg::RA_W-1:0]    rd_addr_o;
  logic [riscv_pkg::XLEN-1:0]    wd_o;
  logic                          we_o;
  logic                          ld_err_o;
  logic [31:0]                   retired_cnt_o;

  // The write-back stage itself
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_result_i,
    input  ld_valid_i, ld_rd_i, ld_rdata_i, ld_addr_lo_i, ld_funct3_i,
    output alu_ready_o, ld_ready_o,
    output rd_addr_o, wd_o, we_o, ld_err_o, retired_cnt_o
  );

  // Producers (ALU, load unit) and consumers (register file, decode bypass)
  modport master (
    output alu_valid_i, alu_rd_i, alu_result_i,
    output ld_valid_i, ld_rd_i, ld_rdata_i, ld_addr_lo_i, ld_funct3_i,
    input  alu_ready_o, ld_ready_o,
    input  rd_addr_o, wd_o, we_o, ld_err_o, retired_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Combinational byte/halfword selection, extension and error check.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        data = {{(XLEN-16){w_half[15]}}, w_half};
        err  = addr_lo[0];
      end
      F3_LHU: begin
        data = {{(XLEN-16){1'b0}}, w_half};
        err  = addr_lo[0];
      end
      F3_LW: begin
        data = rdata;
        err  = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Load-priority write-back arbiter driving the register-file port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage
  import riscv_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  wb_stage_if.slave  bus
);

  logic            w_ld_acc;
  logic            w_alu_acc;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_err;
  wb_result_t      w_sel;

  logic [RA_W-1:0] r_rd_addr;
  logic [XLEN-1:0] r_wd;
  logic            r_we;
  logic            r_ld_err;
  logic [31:0]     r_retired_cnt;

  // The load is always the older instruction, so it wins outright
  assign bus.ld_ready_o  = !rst_i;
  assign bus.alu_ready_o = !rst_i && !bus.ld_valid_i;

  assign w_ld_acc  = bus.ld_valid_i && bus.ld_ready_o;
  assign w_alu_acc = bus.alu_valid_i && bus.alu_ready_o;

  load_align u_load_align (
    .rdata   (bus.ld_rdata_i),
    .addr_lo (bus.ld_addr_lo_i),
    .funct3  (bus.ld_funct3_i),
    .data    (w_ld_data),
    .err     (w_ld_err)
  );

  always_comb begin
    w_sel = '0;
    if (w_ld_acc) begin
      w_sel.rd   = bus.ld_rd_i;
      w_sel.data = w_ld_data;
      w_sel.err  = w_ld_err;
      w_sel.we   = !w_ld_err && (bus.ld_rd_i != '0);
    end else if (w_alu_acc) begin
      w_sel.rd   = bus.alu_rd_i;
      w_sel.data = bus.alu_result_i;
      w_sel.we   = (bus.alu_rd_i != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_addr     <= '0;
      r_wd          <= '0;
      r_we          <= 1'b0;
      r_ld_err      <= 1'b0;
      r_retired_cnt <= '0;
    end else begin
      r_we     <= w_sel.we;
      r_ld_err <= w_sel.err;
      if (w_ld_acc || w_alu_acc) begin
        r_rd_addr     <= w_sel.rd;
        r_wd          <= w_sel.data;
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end
    end
  end

  assign bus.rd_addr_o     = r_rd_addr;
  assign bus.wd_o          = r_wd;
  assign bus.we_o          = r_we;
  assign bus.ld_err_o      = r_ld_err;
  assign bus.retired_cnt_o = r_retired_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed and randomized checks of wb_stage against a reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic clk;
  logic rst;

  wb_stage_if bus ();

  wb_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_cnt = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Load semantics expressed as shifts and masks of the memory word
  function automatic void model_load(input logic [31:0] w, input logic [1:0] a,
                                     input logic [2:0] f3,
                                     output logic [31:0] d, output bit err);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = w >> (8 * int'(a));
    hsh = w >> (16 * int'(a[1]));
    d   = 32'd0;
    err = 1'b0;
    case (f3)
      3'd0: d = {{24{bsh[7]}}, bsh[7:0]};
      3'd4: d = {24'd0, bsh[7:0]};
      3'd1: begin d = {{16{hsh[15]}}, hsh[15:0]}; err = a[0]; end
      3'd5: begin d = {16'd0, hsh[15:0]}; err = a[0]; end
      3'd2: begin d = w; err = (a != 2'd0); end
      default: err = 1'b1;
    endcase
  endfunction

  task automatic set_alu(input bit v, input logic [4:0] rd, input logic [31:0] res);
    bus.alu_valid_i  = v;
    bus.alu_rd_i     = rd;
    bus.alu_result_i = res;
  endtask

  task automatic set_ld(input bit v, input logic [4:0] rd, input logic [31:0] w,
                        input logic [1:0] a, input logic [2:0] f3);
    bus.ld_valid_i   = v;
    bus.ld_rd_i      = rd;
    bus.ld_rdata_i   = w;
    bus.ld_addr_lo_i = a;
    bus.ld_funct3_i  = f3;
  endtask

  // One clock: check readies, predict, clock, check registered outputs
  task automatic run_cycle(output bit alu_taken);
    logic [31:0] d;
    bit          e;
    bit          ld_acc;
    bit          alu_acc;
    bit          exp_we;
    bit          exp_err;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;
    #1;
    check("ld_ready", 32'(bus.ld_ready_o), 32'(!rst));
    check("alu_ready", 32'(bus.alu_ready_o), 32'(!rst && !bus.ld_valid_i));
    ld_acc  = !rst && bus.ld_valid_i;
    alu_acc = !rst && bus.alu_valid_i && !bus.ld_valid_i;
    exp_we  = 1'b0;
    exp_err = 1'b0;
    exp_rd  = 5'd0;
    exp_wd  = 32'd0;
    if (rst) begin
      m_cnt = 32'd0;
    end else if (ld_acc) begin
      model_load(bus.ld_rdata_i, bus.ld_addr_lo_i, bus.ld_funct3_i, d, e);
      exp_err = e;
      exp_we  = !e && (bus.ld_rd_i != 5'd0);
      exp_rd  = bus.ld_rd_i;
      exp_wd  = d;
      m_cnt   = m_cnt + 32'd1;
    end else if (alu_acc) begin
      exp_we  = (bus.alu_rd_i != 5'd0);
      exp_rd  = bus.alu_rd_i;
      exp_wd  = bus.alu_result_i;
      m_cnt   = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    check("we", 32'(bus.we_o), 32'(exp_we));
    check("ld_err", 32'(bus.ld_err_o), 32'(exp_err));
    check("retired_cnt", bus.retired_cnt_o, m_cnt);
    if (exp_we) begin
      check("rd_addr", 32'(bus.rd_addr_o), 32'(exp_rd));
      check("wd", bus.wd_o, exp_wd);
    end
    if (rst) begin
      check("rst_rd_addr", 32'(bus.rd_addr_o), 32'd0);
      check("rst_wd", bus.wd_o, 32'd0);
    end
    alu_taken = alu_acc;
  endtask

  initial begin
    bit taken;
    bit held;
    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'd0);
    set_ld(1'b0, 5'd0, 32'd0, 2'd0, 3'd0);

    repeat (2) run_cycle(taken);
    rst = 1'b0;

    // Plain ALU write
    set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    run_cycle(taken);
    check("alu_taken", 32'(taken), 32'd1);
    check("alu_wd_const", bus.wd_o, 32'hDEAD_BEEF);
    check("alu_cnt_const", bus.retired_cnt_o, 32'd1);
    set_alu(1'b0, 5'd0, 32'd0);

    // Collision: load first, ALU held then retired
    set_alu(1'b1, 5'd3, 32'h11);
    set_ld(1'b1, 5'd4, 32'h22, 2'd0, 3'd2);
    run_cycle(taken);
    check("coll_rd4", 32'(bus.rd_addr_o), 32'd4);
    check("coll_wd22", bus.wd_o, 32'h22);
    set_ld(1'b0, 5'd0, 32'd0, 2'd0, 3'd0);
    run_cycle(taken);
    check("coll_rd3", 32'(bus.rd_addr_o), 32'd3);
    check("coll_wd11", bus.wd_o, 32'h11);
    check("coll_cnt", bus.retired_cnt_o, 32'd3);
    set_alu(1'b0, 5'd0, 32'd0);

    // Alignment and extension of 0x8081_7F80
    set_ld(1'b1, 5'd6, 32'h8081_7F80, 2'd0, 3'd0);
    run_cycle(taken);
    check("lb_a0", bus.wd_o, 32'hFFFF_FF80);
    set_ld(1'b1, 5'd6, 32'h8081_7F80, 2'd1, 3'd4);
    run_cycle(taken);
    check("lbu_a1", bus.wd_o, 32'h0000_007F);
    set_ld(1'b1, 5'd6, 32'h8081_7F80, 2'd2, 3'd1);
    run_cycle(taken);
    check("lh_a2", bus.wd_o, 32'hFFFF_8081);
    set_ld(1'b1, 5'd6, 32'h8081_7F80, 2'd2, 3'd5);
    run_cycle(taken);
    check("lhu_a2", bus.wd_o, 32'h0000_8081);

    // Errored loads
    set_ld(1'b1, 5'd7, 32'h1234_5678, 2'd1, 3'd2);
    run_cycle(taken);
    check("lw_mis_err", 32'(bus.ld_err_o), 32'd1);
    set_ld(1'b1, 5'd7, 32'h1234_5678, 2'd3, 3'd1);
    run_cycle(taken);
    check("lh_mis_we", 32'(bus.we_o), 32'd0);
    set_ld(1'b1, 5'd7, 32'h1234_5678, 2'd0, 3'd3);
    run_cycle(taken);
    check("ill_cnt", bus.retired_cnt_o, 32'd10);
    set_ld(1'b0, 5'd0, 32'd0, 2'd0, 3'd0);

    // Write to x0
    set_alu(1'b1, 5'd0, 32'h1234);
    run_cycle(taken);
    check("x0_we", 32'(bus.we_o), 32'd0);

    // Reset right after an accepted write
    set_alu(1'b1, 5'd9, 32'hCAFE_0001);
    run_cycle(taken);
    rst = 1'b1;
    run_cycle(taken);
    check("rst_cnt", bus.retired_cnt_o, 32'd0);
    rst = 1'b0;
    run_cycle(taken);
    check("post_rst_take", 32'(taken), 32'd1);
    set_alu(1'b0, 5'd0, 32'd0);

    // Counter wrap
    force dut.r_retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired_cnt;
    m_cnt = 32'hFFFF_FFFF;
    check("cnt_forced", bus.retired_cnt_o, 32'hFFFF_FFFF);
    set_alu(1'b1, 5'd2, 32'h5A5A_5A5A);
    run_cycle(taken);
    check("cnt_wrap", bus.retired_cnt_o, 32'd0);
    set_alu(1'b0, 5'd0, 32'd0);

    // Randomized traffic; a stalled ALU result is held stable
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held)
        set_alu($urandom_range(0, 9) < 6, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                $urandom);
      set_ld($urandom_range(0, 9) < 4, 5'($urandom_range(0, 4) == 0 ? 0 : $urandom),
             $urandom, 2'($urandom), 3'($urandom));
      rst = ($urandom_range(0, 49) == 0);
      run_cycle(taken);
      held = bus.alu_valid_i && !taken;
    end
    rst = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0);
    set_ld(1'b0, 5'd0, 32'd0, 2'd0, 3'd0);
    run_cycle(taken);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
